// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: 4x4 matrix keypad scanner feeding an N-digit entry buffer
// with backspace (key or debounced button), clear, commit and timed LEDs.
module keypad_entry_ctrl #(
   parameter int N_DIGITS  = 8,
   parameter int SCAN_TICK = 1_048_576,
   parameter int DB_CYCLES = 1_000_000,
   parameter int LED_HOLD  = 100_000_000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          back_btn,
   input  logic [3:0]                    row,
   output logic [3:0]                    col,
   output logic [4*N_DIGITS-1:0]         shown,
   output logic [$clog2(N_DIGITS+1)-1:0] count,
   output logic                          key_valid,
   output logic [3:0]                    key_code,
   output logic                          commit,
   output logic [4*N_DIGITS-1:0]         word,
   output logic                          led_error,
   output logic                          led_back
);
   localparam int CW = $clog2(N_DIGITS+1);
   localparam int TW = $clog2(SCAN_TICK+1);
   localparam int DW = $clog2(DB_CYCLES+1);
   localparam int LW = $clog2(LED_HOLD+1);
   localparam int SW = 4*N_DIGITS;

   typedef enum logic [2:0] {IDLE, SCAN0, SCAN1, SCAN2, SCAN3, PRESSED} state_t;

   state_t          state, state_n;
   logic [TW-1:0]   tick_cnt;
   logic            tick;
   logic [3:0]      cap_col, cap_row;
   logic            pend, key_ok, kv;
   logic [3:0]      code;
   logic [1:0]      bsync;
   logic            db_level, db_flip, bk_rise;
   logic [DW-1:0]   db_cnt;
   logic [SW-1:0]   shown_n, word_n;
   logic [CW-1:0]   count_n;
   logic            commit_n, trig_err, trig_back, do_bksp;
   logic [LW-1:0]   err_cnt, back_cnt;

   assign tick = (tick_cnt == TW'(SCAN_TICK-1));

   // free-running scan-step divider, restarts on disable
   always_ff @(posedge clk or posedge rst) begin
      if (rst)               tick_cnt <= '0;
      else if (!en || tick)  tick_cnt <= '0;
      else                   tick_cnt <= tick_cnt + 1'b1;
   end

   // scan FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      state <= IDLE;
      else if (!en) state <= IDLE;
      else          state <= state_n;
   end

   // scan FSM next state: every move happens only on a tick
   always_comb begin
      state_n = state;
      if (tick) begin
         case (state)
            IDLE:    if (row != 4'hF) state_n = SCAN0;
            SCAN0:   state_n = (row != 4'hF) ? PRESSED : SCAN1;
            SCAN1:   state_n = (row != 4'hF) ? PRESSED : SCAN2;
            SCAN2:   state_n = (row != 4'hF) ? PRESSED : SCAN3;
            SCAN3:   state_n = (row != 4'hF) ? PRESSED : IDLE;
            PRESSED: if (row == 4'hF) state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   // column drive: all low while idle so any key shows up, one low while scanning
   always_comb begin
      case (state)
         SCAN0:   col = 4'b1110;
         SCAN1:   col = 4'b1101;
         SCAN2:   col = 4'b1011;
         SCAN3:   col = 4'b0111;
         PRESSED: col = cap_col;
         default: col = 4'b0000;
      endcase
   end

   // capture the key on entry to PRESSED; pend marks the single event cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_col <= 4'hF;
         cap_row <= 4'hF;
         pend    <= 1'b0;
      end else if (!en) begin
         pend    <= 1'b0;
      end else begin
         pend <= 1'b0;
         if (state != PRESSED && state_n == PRESSED) begin
            cap_col <= col;
            cap_row <= row;
            pend    <= 1'b1;
         end
      end
   end

   // key map; any row pattern with more than one low bit falls to default
   always_comb begin
      key_ok = 1'b1;
      code   = 4'h0;
      case ({cap_col, cap_row})
         8'hEE: code = 4'h1;  8'hED: code = 4'h4;  8'hEB: code = 4'h7;  8'hE7: code = 4'hE;
         8'hDE: code = 4'h2;  8'hDD: code = 4'h5;  8'hDB: code = 4'h8;  8'hD7: code = 4'hA;
         8'hBE: code = 4'h3;  8'hBD: code = 4'h6;  8'hBB: code = 4'h9;  8'hB7: code = 4'hF;
         8'h7E: code = 4'hB;  8'h7D: code = 4'hC;  8'h7B: code = 4'hD;  8'h77: code = 4'h0;
         default: key_ok = 1'b0;
      endcase
   end

   assign kv      = pend && key_ok;
   assign db_flip = (bsync[1] != db_level) && (db_cnt == DW'(DB_CYCLES-1));
   assign bk_rise = db_flip && bsync[1];

   // back button: two-flop sync, then level only moves after DB_CYCLES equal samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst || !en) begin
         bsync    <= 2'b00;
         db_level <= 1'b0;
         db_cnt   <= '0;
      end else begin
         bsync <= {bsync[0], back_btn};
         if (bsync[1] == db_level) db_cnt <= '0;
         else if (db_flip) begin
            db_level <= bsync[1];
            db_cnt   <= '0;
         end else db_cnt <= db_cnt + 1'b1;
      end
   end

   // buffer actions; a button backspace wins over a same-cycle keypad event
   always_comb begin
      shown_n   = shown;
      count_n   = count;
      word_n    = word;
      commit_n  = 1'b0;
      trig_err  = 1'b0;
      trig_back = 1'b0;
      do_bksp   = bk_rise || (kv && code == 4'h0);
      if (do_bksp) begin
         if (count != '0) begin
            shown_n = shown >> 4;
            count_n = count - 1'b1;
         end else trig_back = 1'b1;
      end else if (kv) begin
         case (code)
            4'hE: begin
               shown_n = '0;
               count_n = '0;
            end
            4'hF: begin
               if (count != '0) begin
                  word_n   = shown;
                  commit_n = 1'b1;
                  shown_n  = '0;
                  count_n  = '0;
               end else trig_err = 1'b1;
            end
            default: begin
               if (count == CW'(N_DIGITS)) trig_err = 1'b1;
               else begin
                  shown_n      = shown << 4;
                  shown_n[3:0] = code;
                  count_n      = count + 1'b1;
               end
            end
         endcase
      end
   end

   // buffer, event and commit registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst || !en) begin
         shown     <= '0;
         count     <= '0;
         word      <= '0;
         commit    <= 1'b0;
         key_valid <= 1'b0;
         key_code  <= 4'h0;
      end else begin
         shown     <= shown_n;
         count     <= count_n;
         word      <= word_n;
         commit    <= commit_n;
         key_valid <= kv;
         if (kv) key_code <= code;
      end
   end

   // LED hold counters: trigger reloads 0, count up and saturate at LED_HOLD (dark)
   always_ff @(posedge clk or posedge rst) begin
      if (rst || !en) begin
         err_cnt  <= LW'(LED_HOLD);
         back_cnt <= LW'(LED_HOLD);
      end else begin
         if (trig_err)                          err_cnt <= '0;
         else if (err_cnt != LW'(LED_HOLD))     err_cnt <= err_cnt + 1'b1;
         if (trig_back)                         back_cnt <= '0;
         else if (back_cnt != LW'(LED_HOLD))    back_cnt <= back_cnt + 1'b1;
      end
   end

   assign led_error = (err_cnt  < LW'(LED_HOLD));
   assign led_back  = (back_cnt < LW'(LED_HOLD));

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Scoreboard bench for keypad_entry_ctrl: stimulus pushes expected key events,
// commits and LED pulse widths; a monitor pops and compares as the DUT emits them.
module tb_keypad_entry_ctrl;
   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst, en, back_btn;
   logic [3:0]  row, col;
   logic [15:0] shown, word;
   logic [2:0]  count;
   logic        key_valid, commit, led_error, led_back;
   logic [3:0]  key_code;
   logic [15:0] key_down;

   typedef struct {
      logic [3:0]  code;
      logic [15:0] shown;
      int          count;
   } kev_t;

   kev_t        kq[$];
   logic [15:0] wq[$];
   int          errq[$];
   int          backq[$];
   int          errors = 0;
   int          checks = 0;
   int          ew = 0;
   int          bw = 0;

   keypad_entry_ctrl #(.N_DIGITS(N), .SCAN_TICK(4), .DB_CYCLES(3), .LED_HOLD(10)) dut (
      .clk(clk), .rst(rst), .en(en), .back_btn(back_btn), .row(row), .col(col),
      .shown(shown), .count(count), .key_valid(key_valid), .key_code(key_code),
      .commit(commit), .word(word), .led_error(led_error), .led_back(led_back)
   );

   always #5 clk = ~clk;

   // keypad model: a held key pulls its row low whenever its column is driven low
   always_comb begin
      row = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (key_down[c*4+r] && !col[c]) row[r] = 1'b0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_key(input logic [3:0] c, input logic [15:0] s, input int n);
      kev_t e;
      e.code = c; e.shown = s; e.count = n;
      kq.push_back(e);
   endtask

   task automatic press(input int c, input int r);
      @(negedge clk) key_down = 16'(1) << (c*4+r);
      repeat (40) @(negedge clk);
      key_down = '0;
      repeat (24) @(negedge clk);
   endtask

   // monitor: compares every output event against the head of its queue
   initial begin
      kev_t e;
      forever begin
         @(negedge clk);
         if (key_valid) begin
            if (kq.size() == 0) begin
               checks++; errors++;
               $display("FAIL spurious_key_valid: key_code=%0h with no event expected", key_code);
            end else begin
               e = kq.pop_front();
               chk("key_code", 32'(key_code), 32'(e.code));
               chk("shown_at_event", 32'(shown), 32'(e.shown));
               chk("count_at_event", 32'(count), 32'(e.count));
            end
         end
         if (commit) begin
            if (wq.size() == 0) begin
               checks++; errors++;
               $display("FAIL spurious_commit: word=%0h with no commit expected", word);
            end else chk("commit_word", 32'(word), 32'(wq.pop_front()));
         end
         if (led_error) ew++;
         else if (ew > 0) begin
            if (errq.size() == 0) begin
               checks++; errors++;
               $display("FAIL spurious_led_error: width %0d with no trigger expected", ew);
            end else chk("led_error_width", 32'(ew), 32'(errq.pop_front()));
            ew = 0;
         end
         if (led_back) bw++;
         else if (bw > 0) begin
            if (backq.size() == 0) begin
               checks++; errors++;
               $display("FAIL spurious_led_back: width %0d with no trigger expected", bw);
            end else chk("led_back_width", 32'(bw), 32'(backq.pop_front()));
            bw = 0;
         end
      end
   end

   // directed stimulus
   initial begin
      rst = 1'b1; en = 1'b1; back_btn = 1'b0; key_down = '0;
      repeat (3) @(negedge clk);
      chk("rst_col", 32'(col), 32'h0);
      chk("rst_shown", 32'(shown), 32'h0);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_key_valid", 32'(key_valid), 32'h0);
      chk("rst_key_code", 32'(key_code), 32'h0);
      chk("rst_commit", 32'(commit), 32'h0);
      chk("rst_word", 32'(word), 32'h0);
      chk("rst_leds", 32'({led_error, led_back}), 32'h0);
      rst = 1'b0;

      // single press held well over 5 ticks -> exactly one event
      expect_key(4'h2, 16'h0002, 1); press(1, 0);

      // fill 1,2,3,4 then overflow with 5
      expect_key(4'hE, 16'h0000, 0); press(0, 3);
      expect_key(4'h1, 16'h0001, 1); press(0, 0);
      expect_key(4'h2, 16'h0012, 2); press(1, 0);
      expect_key(4'h3, 16'h0123, 3); press(2, 0);
      expect_key(4'h4, 16'h1234, 4); press(0, 1);
      expect_key(4'h5, 16'h1234, 4); errq.push_back(10); press(1, 1);

      // back button: long pulse deletes one, glitch ignored
      expect_key(4'hE, 16'h0000, 0); press(0, 3);
      expect_key(4'h1, 16'h0001, 1); press(0, 0);
      expect_key(4'h2, 16'h0012, 2); press(1, 0);
      @(negedge clk) back_btn = 1'b1;
      repeat (5) @(negedge clk);
      back_btn = 1'b0;
      repeat (20) @(negedge clk);
      chk("btn_bksp_shown", 32'(shown), 32'h0001);
      chk("btn_bksp_count", 32'(count), 32'd1);
      back_btn = 1'b1;
      @(negedge clk) back_btn = 1'b0;
      repeat (20) @(negedge clk);
      chk("btn_glitch_shown", 32'(shown), 32'h0001);
      expect_key(4'h0, 16'h0000, 0); press(3, 3);
      expect_key(4'h0, 16'h0000, 0); backq.push_back(10); press(3, 3);

      // commit and commit-on-empty
      expect_key(4'h7, 16'h0007, 1); press(0, 2);
      expect_key(4'h8, 16'h0078, 2); press(1, 2);
      expect_key(4'h9, 16'h0789, 3); press(2, 2);
      expect_key(4'hF, 16'h0000, 0); wq.push_back(16'h0789); press(2, 3);
      expect_key(4'hF, 16'h0000, 0); errq.push_back(10); press(2, 3);
      chk("word_kept", 32'(word), 32'h0789);

      // two keys in one column: discarded, buffer untouched
      expect_key(4'hD, 16'h000D, 1); press(3, 2);
      @(negedge clk) key_down = 16'h0003;
      repeat (40) @(negedge clk);
      key_down = '0;
      repeat (24) @(negedge clk);
      chk("multi_shown", 32'(shown), 32'h000D);
      chk("multi_count", 32'(count), 32'd1);

      // async reset while a key is held in PRESSED with count=3
      expect_key(4'hE, 16'h0000, 0); press(0, 3);
      expect_key(4'h1, 16'h0001, 1); press(0, 0);
      expect_key(4'h2, 16'h0012, 2); press(1, 0);
      expect_key(4'h3, 16'h0123, 3);
      @(negedge clk) key_down = 16'h0100;
      repeat (40) @(negedge clk);
      rst = 1'b1;
      #2;
      chk("midrst_col", 32'(col), 32'h0);
      chk("midrst_shown", 32'(shown), 32'h0);
      chk("midrst_count", 32'(count), 32'h0);
      chk("midrst_key_code", 32'(key_code), 32'h0);
      chk("midrst_word", 32'(word), 32'h0);
      @(negedge clk) rst = 1'b0;
      expect_key(4'h3, 16'h0003, 1);
      repeat (40) @(negedge clk);
      key_down = '0;
      repeat (50) @(negedge clk);

      chk("pending_key_events", 32'(kq.size()), 32'd0);
      chk("pending_commits", 32'(wq.size()), 32'd0);
      chk("pending_led_error", 32'(errq.size()), 32'd0);
      chk("pending_led_back", 32'(backq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/keypad_entry_ctrl.md
# keypad_entry_ctrl

Parametrised 4x4 matrix-keypad scanner and N-digit entry buffer with backspace, clear, enter/commit and timed error/back indicator LEDs. It sits between the board keypad and button pins and the display and Morse-encoding logic. It replaces the fixed 8-digit, 3-column keypad entry block. New capabilities: a full 16-key map, configurable depth, scan rate and LED hold time, a clock-enable scan tick instead of a derived clock, multi-key rejection, and a committed-word output.

## Interface
- N_DIGITS, 8: buffer depth in 4-bit symbols (1..16).
- SCAN_TICK, 1_048_576: clk cycles per scan-FSM step.
- DB_CYCLES, 1_000_000: cycles `back_btn` must be stable to be accepted.
- LED_HOLD, 100_000_000: cycles an indicator LED stays lit after a trigger.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  block enable; low acts as a synchronous clear to reset values.
- back_btn  in  1  raw backspace push-button, active-high.
- row  in  4  keypad rows, active-low, pulled up.
- col  out  4  keypad column drive, active-low.
- shown  out  4*N_DIGITS  entry buffer; nibble 0 holds the newest symbol; 0x0 means an empty slot.
- count  out  $clog2(N_DIGITS+1)  number of symbols held.
- key_valid  out  1  one-cycle pulse per accepted key press.
- key_code  out  4  code of the last accepted key; held until the next press.
- commit  out  1  one-cycle pulse when a word is committed.
- word  out  4*N_DIGITS  last committed buffer contents.
- led_error  out  1  error indicator.
- led_back  out  1  back-on-empty indicator.

## Operation
- A tick is a one-cycle enable, asserted every SCAN_TICK cycles by a free-running counter. The counter is cleared by rst or !en.
- Scan FSM states, all advancing only on a tick:
  - IDLE: col=0000. If row≠F, go to SCAN0.
  - SCANk (k=0..3): col drives bit k low, others high (SCAN0 col=1110 … SCAN3 col=0111). If row≠F, go to PRESSED and capture {col,row}. Otherwise go to SCANk+1; from SCAN3, go to IDLE.
  - PRESSED: col holds. If row=F, go to IDLE; otherwise stay.
- Key event:
  - Generated on the cycle after the FSM enters PRESSED, exactly once per press.
  - A captured row with more than one low bit (multi-key) is discarded: no key_valid.
- Key map, by column (col bit low) then row (row bit low), rows 0..3:
  - Col 0: 1, 4, 7, `*`=0xE.
  - Col 1: 2, 5, 8, `0`=0xA.
  - Col 2: 3, 6, 9, `#`=0xF.
  - Col 3: 0xB, 0xC, 0xD, BKSP=0x0.
- Buffer actions:
  - Symbol (1..0xD), count<N: shift `shown` left by 4 and insert the symbol into nibble 0; count+1.
  - Symbol, count=N: buffer unchanged; trigger error.
  - BKSP (key or accepted back_btn rising edge), count>0: shift `shown` right by 4 with 0 entering the top; count−1.
  - BKSP, count=0: buffer unchanged; trigger back.
  - `*`: shown=0, count=0; no LED.
  - `#`, count>0: word←shown, commit pulse, then shown=0, count=0 (same edge).
  - `#`, count=0: trigger error; word unchanged.
- back_btn path:
  - Two-flop synchroniser feeds a debounce counter.
  - The debounced level changes only after DB_CYCLES consecutive equal samples.
  - Its rising edge is one BKSP event.
- Same-cycle back_btn edge and keypad event: the back_btn BKSP is applied. The keypad event still pulses key_valid/key_code but makes no buffer change.
- LEDs:
  - Each has a counter loaded with 0 on trigger; the LED is lit while counter<LED_HOLD, saturating at LED_HOLD.
  - A retrigger while lit restarts the full hold.

## Timing
- Reset values: col=0000, shown=0, count=0, key_valid=0, key_code=0, commit=0, word=0, led_error=0, led_back=0, FSM=IDLE.
- !en applies the same values synchronously; the debouncer and LED counters are cleared as well.
- Reset or !en mid-press: the FSM goes to IDLE. A press still held afterwards is re-detected as a new event after IDLE→SCANk→PRESSED.
- Latency from a row change to key_valid: 2–6 ticks plus 1 clk.
- key_valid, the buffer update, commit and the LED first-lit edge all occur on the same clk edge.
- Press-and-hold produces one event only; a new event requires row=F seen at a tick.

## Test plan
Bench parameters: N_DIGITS=4, SCAN_TICK=4, DB_CYCLES=3, LED_HOLD=10.
- Press col1/row0, hold 5 ticks, release → exactly one key_valid, key_code=2, shown=0x0002, count=1.
- Enter 1,2,3,4, then 5 → shown=0x1234, count=4; led_error high for exactly 10 cycles; the 5 is dropped.
- shown=0x0012, pulse back_btn for 5 cycles, then for 1 cycle → shown=0x0001 after the first pulse; the 1-cycle glitch is ignored. Col3/row3 key → shown=0. Second BKSP → led_back lit for 10 cycles.
- shown=0x0789, press `#` → commit pulse, word=0x0789, shown=0, count=0. Press `#` again → led_error; word still 0x0789.
- Press col0/row0 and col0/row1 simultaneously → no key_valid; buffer unchanged.
- Assert rst (async) during PRESSED with count=3 → all outputs at reset values immediately. Deassert while still pressed → one new key_valid after a rescan.
